// File: rtl/rc_pkg.sv
// Shared constants and the route function for the wormhole route-computation array.
package rc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_W = 2;
    localparam int P_S = 3;
    localparam int P_L = 4;

    localparam logic [NUM_PORTS-1:0] DIR_N = 5'b00001;
    localparam logic [NUM_PORTS-1:0] DIR_E = 5'b00010;
    localparam logic [NUM_PORTS-1:0] DIR_W = 5'b00100;
    localparam logic [NUM_PORTS-1:0] DIR_S = 5'b01000;
    localparam logic [NUM_PORTS-1:0] DIR_L = 5'b10000;

    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    // Coordinates are zero-extended to this width before routing; COORD_W must not exceed it.
    localparam int MAX_COORD_W = 8;

    typedef enum logic {ST_IDLE, ST_PKT} port_state_e;

    function automatic logic [NUM_PORTS-1:0] route_fn(
        input logic [MAX_COORD_W-1:0] dx,
        input logic [MAX_COORD_W-1:0] dy,
        input logic [MAX_COORD_W-1:0] mx,
        input logic [MAX_COORD_W-1:0] my,
        input logic                   mode
    );
        logic [NUM_PORTS-1:0] xdir, ydir, r;
        xdir = (dx > mx) ? DIR_E : (dx < mx) ? DIR_W : '0;
        ydir = (dy > my) ? DIR_N : (dy < my) ? DIR_S : '0;
        if (mode) r = (|ydir) ? ydir : (|xdir) ? xdir : DIR_L;
        else      r = (|xdir) ? xdir : (|ydir) ? ydir : DIR_L;
        return r;
    endfunction

endpackage

// File: rtl/rc_port.sv
// One input port: wormhole packet tracker, route register, circular flit buffer, sticky error flag.
module rc_port
    import rc_pkg::*;
#(
    parameter int DATASIZE   = 40,
    parameter int COORD_W    = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int ROUTE_MODE = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [2*COORD_W-1:0]   id_i,
    input  logic [DATASIZE-1:0]    data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATASIZE-1:0]    data_o,
    output logic [NUM_PORTS-1:0]   dir_o,
    output logic                   winc_o,
    input  logic                   wfull_i,
    input  logic                   err_clr_i,
    output logic                   err_o
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [DATASIZE-1:0]  mem_data_q [BUF_DEPTH];
    logic [NUM_PORTS-1:0] mem_dir_q  [BUF_DEPTH];
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        cnt_q;
    port_state_e          st_q, st_d;
    logic [NUM_PORTS-1:0] route_q, route_d, new_route, push_dir;
    logic                 err_q, err_d, err_set;
    logic                 push, pop, acc, empty;
    logic [1:0]           ftype;
    logic [COORD_W-1:0]   dx, dy, mx, my;

    assign ftype     = data_i[DATASIZE-1 -: 2];
    assign {dx, dy}  = data_i[DATASIZE-3 -: 2*COORD_W];
    assign {mx, my}  = id_i;
    assign new_route = route_fn(MAX_COORD_W'(dx), MAX_COORD_W'(dy),
                                MAX_COORD_W'(mx), MAX_COORD_W'(my), ROUTE_MODE != 0);

    assign empty   = (cnt_q == '0);
    // Readiness depends on occupancy only, so a full buffer refuses even while draining.
    assign ready_o = (cnt_q != CW'(BUF_DEPTH));
    assign acc     = valid_i & ready_o;
    assign pop     = !empty & !wfull_i;
    assign winc_o  = pop;
    assign data_o  = empty ? '0 : mem_data_q[rptr_q];
    assign dir_o   = empty ? '0 : mem_dir_q[rptr_q];
    assign err_o   = err_q;

    always_comb begin
        st_d     = st_q;
        route_d  = route_q;
        push     = 1'b0;
        push_dir = route_q;
        err_set  = 1'b0;
        if (acc) begin
            unique case (ftype)
                FT_HEAD: begin
                    push     = 1'b1;
                    push_dir = new_route;
                    route_d  = new_route;
                    st_d     = ST_PKT;
                    err_set  = (st_q == ST_PKT);
                end
                FT_SINGLE: begin
                    push     = 1'b1;
                    push_dir = new_route;
                    st_d     = ST_IDLE;
                    err_set  = (st_q == ST_PKT);
                end
                FT_BODY: begin
                    push    = (st_q == ST_PKT);
                    err_set = (st_q == ST_IDLE);
                end
                default: begin
                    push    = (st_q == ST_PKT);
                    err_set = (st_q == ST_IDLE);
                    st_d    = ST_IDLE;
                end
            endcase
        end
        err_d = err_clr_i ? 1'b0 : (err_q | err_set);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= ST_IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            route_q <= route_d;
            err_q   <= err_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the outputs are masked to zero whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wptr_q] <= data_i;
            mem_dir_q[wptr_q]  <= push_dir;
        end
    end

endmodule

// File: rtl/rc_wormhole_array.sv
// Five-port route-computation stage: one independent rc_port per mesh input (N, E, W, S, L).
module rc_wormhole_array
    import rc_pkg::*;
#(
    parameter int DATASIZE   = 40,
    parameter int COORD_W    = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int ROUTE_MODE = 0
) (
    input  logic                            rc_clk,
    input  logic                            rst_n,
    input  logic [2*COORD_W-1:0]            ID,
    input  logic [NUM_PORTS*DATASIZE-1:0]   data_in,
    input  logic [NUM_PORTS-1:0]            valid_in,
    output logic [NUM_PORTS-1:0]            fifo_ready,
    output logic [NUM_PORTS*DATASIZE-1:0]   data_out,
    output logic [NUM_PORTS*NUM_PORTS-1:0]  direction_out,
    output logic [NUM_PORTS-1:0]            infifo_winc,
    input  logic [NUM_PORTS-1:0]            infifo_wfull,
    input  logic                            err_clr,
    output logic [NUM_PORTS-1:0]            err_flag
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rc_port #(
            .DATASIZE  (DATASIZE),
            .COORD_W   (COORD_W),
            .BUF_DEPTH (BUF_DEPTH),
            .ROUTE_MODE(ROUTE_MODE)
        ) u_port (
            .clk_i    (rc_clk),
            .rst_ni   (rst_n),
            .id_i     (ID),
            .data_i   (data_in[p*DATASIZE +: DATASIZE]),
            .valid_i  (valid_in[p]),
            .ready_o  (fifo_ready[p]),
            .data_o   (data_out[p*DATASIZE +: DATASIZE]),
            .dir_o    (direction_out[p*NUM_PORTS +: NUM_PORTS]),
            .winc_o   (infifo_winc[p]),
            .wfull_i  (infifo_wfull[p]),
            .err_clr_i(err_clr),
            .err_o    (err_flag[p])
        );
    end

endmodule

// File: tb/tb_rc_wormhole_array.sv
// Randomized bench: an XY and a YX instance share stimulus and are checked against a queue model.
module tb_rc_wormhole_array;
    localparam int DS = 40;
    localparam int NP = 5;
    localparam int DEPTH = 4;
    localparam int W = NP*DS;

    logic            rc_clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      ID;
    logic [W-1:0]    data_in;
    logic [NP-1:0]   valid_in, infifo_wfull;
    logic            err_clr;
    logic [NP-1:0]   rdy0, rdy1, winc0, winc1, err0, err1;
    logic [W-1:0]    dout0, dout1;
    logic [NP*NP-1:0] dir0, dir1;

    int n_tests = 0;
    int n_fail = 0;

    always #5 rc_clk = ~rc_clk;

    rc_wormhole_array #(.DATASIZE(DS), .COORD_W(2), .BUF_DEPTH(DEPTH), .ROUTE_MODE(0)) u_xy (
        .rc_clk(rc_clk), .rst_n(rst_n), .ID(ID), .data_in(data_in), .valid_in(valid_in),
        .fifo_ready(rdy0), .data_out(dout0), .direction_out(dir0), .infifo_winc(winc0),
        .infifo_wfull(infifo_wfull), .err_clr(err_clr), .err_flag(err0));

    rc_wormhole_array #(.DATASIZE(DS), .COORD_W(2), .BUF_DEPTH(DEPTH), .ROUTE_MODE(1)) u_yx (
        .rc_clk(rc_clk), .rst_n(rst_n), .ID(ID), .data_in(data_in), .valid_in(valid_in),
        .fifo_ready(rdy1), .data_out(dout1), .direction_out(dir1), .infifo_winc(winc1),
        .infifo_wfull(infifo_wfull), .err_clr(err_clr), .err_flag(err1));

    typedef struct {
        logic [DS-1:0] d;
        logic [4:0]    r0;
        logic [4:0]    r1;
    } ent_t;

    ent_t       mq [NP][$];
    bit         m_pkt [NP];
    logic [4:0] m_rt0 [NP];
    logic [4:0] m_rt1 [NP];
    bit         m_err [NP];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Direction from the routing rule: the first dimension that differs wins, else local.
    function automatic logic [4:0] ref_route(int dx, int dy, int mx, int my, bit yx);
        int xd, yd;
        xd = dx - mx;
        yd = dy - my;
        if (yx && yd != 0) return (yd > 0) ? 5'b00001 : 5'b01000;
        if (xd != 0)       return (xd > 0) ? 5'b00010 : 5'b00100;
        if (yd != 0)       return (yd > 0) ? 5'b00001 : 5'b01000;
        return 5'b10000;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            m_pkt[p] = 0;
            m_err[p] = 0;
            m_rt0[p] = '0;
            m_rt1[p] = '0;
        end
    endtask

    task automatic check_all();
        logic [NP-1:0]    er, ew, ee;
        logic [W-1:0]     ed;
        logic [NP*NP-1:0] e0, e1;
        er = '0; ew = '0; ee = '0; ed = '0; e0 = '0; e1 = '0;
        for (int p = 0; p < NP; p++) begin
            er[p] = mq[p].size() < DEPTH;
            ew[p] = (mq[p].size() > 0) && !infifo_wfull[p];
            ee[p] = m_err[p];
            if (mq[p].size() > 0) begin
                ed[p*DS +: DS] = mq[p][0].d;
                e0[p*NP +: NP] = mq[p][0].r0;
                e1[p*NP +: NP] = mq[p][0].r1;
            end
        end
        if (rst_n) begin
            chk("ready_xy", W'(rdy0), W'(er));
            chk("ready_yx", W'(rdy1), W'(er));
        end
        chk("winc_xy", W'(winc0), W'(ew));
        chk("winc_yx", W'(winc1), W'(ew));
        chk("data_xy", dout0, ed);
        chk("data_yx", dout1, ed);
        chk("dir_xy", W'(dir0), W'(e0));
        chk("dir_yx", W'(dir1), W'(e1));
        chk("err_xy", W'(err0), W'(ee));
        chk("err_yx", W'(err1), W'(ee));
    endtask

    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            logic [DS-1:0] f;
            logic [1:0]    t;
            logic [4:0]    n0, n1;
            ent_t          e;
            bit            acc, es, do_push;
            f = data_in[p*DS +: DS];
            t = f[DS-1 -: 2];
            acc = valid_in[p] && (mq[p].size() < DEPTH);
            es = 0;
            do_push = 0;
            n0 = ref_route(int'(f[DS-3 -: 2]), int'(f[DS-5 -: 2]), int'(ID[3:2]), int'(ID[1:0]), 0);
            n1 = ref_route(int'(f[DS-3 -: 2]), int'(f[DS-5 -: 2]), int'(ID[3:2]), int'(ID[1:0]), 1);
            if ((mq[p].size() > 0) && !infifo_wfull[p]) void'(mq[p].pop_front());
            if (acc) begin
                case (t)
                    2'b10: begin
                        es = m_pkt[p]; m_pkt[p] = 1; m_rt0[p] = n0; m_rt1[p] = n1;
                        e.r0 = n0; e.r1 = n1; do_push = 1;
                    end
                    2'b11: begin
                        es = m_pkt[p]; m_pkt[p] = 0;
                        e.r0 = n0; e.r1 = n1; do_push = 1;
                    end
                    default: begin
                        if (m_pkt[p]) begin
                            e.r0 = m_rt0[p]; e.r1 = m_rt1[p]; do_push = 1;
                            if (t == 2'b01) m_pkt[p] = 0;
                        end else es = 1;
                    end
                endcase
                if (do_push) begin
                    e.d = f;
                    mq[p].push_back(e);
                end
            end
            m_err[p] = err_clr ? 1'b0 : (m_err[p] | es);
        end
    endtask

    // Called just after a falling edge with inputs set; leaves at the next falling edge.
    task automatic tick();
        #1;
        if (!rst_n) model_reset();
        check_all();
        if (rst_n) model_step();
        @(negedge rc_clk);
        valid_in = '0;
        err_clr = 1'b0;
    endtask

    task automatic put(input int p, input logic [1:0] t, input logic [3:0] dest);
        logic [63:0] r;
        r = {$urandom, $urandom};
        data_in[p*DS +: DS] = {t, dest, r[DS-7:0]};
        valid_in[p] = 1'b1;
    endtask

    initial begin
        ID = 4'b0101;
        data_in = '0;
        valid_in = '0;
        infifo_wfull = '0;
        err_clr = 1'b0;
        model_reset();
        @(negedge rc_clk);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", W'(rdy0), W'(5'h1f));

        // N: head/body/tail to {3,0}
        put(0, 2'b10, 4'b1100);
        tick();
        put(0, 2'b00, 4'b0000);
        #1;
        chk("n_head_winc", W'(winc0[0]), W'(1'b1));
        chk("n_head_dir_xy", W'(dir0[4:0]), W'(5'b00010));
        chk("n_head_dir_yx", W'(dir1[4:0]), W'(5'b01000));
        tick();
        put(0, 2'b01, 4'b0000);
        tick();
        repeat (3) tick();

        // E: backpressure fills the buffer
        infifo_wfull[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            put(1, (i == 0) ? 2'b10 : 2'b00, 4'b0000);
            tick();
            if (i == 3) chk("e_full_ready", W'(rdy0[1]), W'(1'b0));
        end
        infifo_wfull[1] = 1'b0;
        tick();
        chk("e_ready_back", W'(rdy0[1]), W'(1'b1));
        repeat (4) tick();
        put(1, 2'b01, 4'b0000);
        tick();

        // W: body while idle, then clear
        put(2, 2'b00, 4'b0000);
        tick();
        chk("w_err_set", W'(err0[2]), W'(1'b1));
        err_clr = 1'b1;
        tick();
        chk("w_err_clr", W'(err0[2]), W'(1'b0));

        // L: single addressed to this router
        put(4, 2'b11, 4'b0101);
        tick();
        #1;
        chk("l_single_dir", W'(dir0[24:20]), W'(5'b10000));
        chk("l_single_winc", W'(winc0[4]), W'(1'b1));
        repeat (2) tick();

        // S: reset with two flits buffered
        infifo_wfull[3] = 1'b1;
        put(3, 2'b10, 4'b1111);
        tick();
        put(3, 2'b00, 4'b0000);
        tick();
        rst_n = 1'b0;
        #1;
        chk("s_rst_data", W'(dout0[3*DS +: DS]), W'(0));
        tick();
        infifo_wfull = '0;
        rst_n = 1'b1;
        tick();
        put(3, 2'b00, 4'b0000);
        tick();
        chk("s_body_err", W'(err0[3]), W'(1'b1));

        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                int k;
                k = $urandom_range(0, 9);
                put(p, (k < 3) ? 2'b10 : (k < 6) ? 2'b00 : (k < 8) ? 2'b01 : 2'b11,
                    4'($urandom));
                valid_in[p] = ($urandom_range(0, 3) != 0);
                infifo_wfull[p] = ($urandom_range(0, 2) == 0);
            end
            err_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) ID = 4'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
